// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, datapath width and controller states shared by the ALU arbiter slice
package alu_pkg;
    localparam int ALU_W = 32;
    localparam logic [2:0] ALU_OP_ADD = 3'b011;
    localparam logic [2:0] ALU_OP_SUB = 3'b100;
    localparam logic [2:0] ALU_OP_OR  = 3'b101;
    localparam logic [2:0] ALU_OP_AND = 3'b110;
    localparam logic [2:0] ALU_OP_SHL = 3'b111;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: requester-side request/response bundle of the shared ALU
interface alu_share_arb_if #(parameter int NREQ = 2, parameter int W = 32);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*3-1:0] req_op;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_result;
    logic              rsp_zero;
    modport master (output req_valid, req_a, req_b, req_op, rsp_ready,
                    input  req_ready, rsp_valid, rsp_result, rsp_zero);
    modport slave  (input  req_valid, req_a, req_b, req_op, rsp_ready,
                    output req_ready, rsp_valid, rsp_result, rsp_zero);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant plus index; round-robin from ptr, or lowest index when ALU_ARB_FIXED_PRIO_EN is defined
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);
    logic found;
    int k;
`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif
    always_comb begin
        gnt = '0;
        idx = '0;
        found = 1'b0;
        k = 0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            k = i;
`else
            k = (int'(ptr) + i) % NREQ;
`endif
            if (!found && req[k]) begin
                found = 1'b1;
                gnt[k] = 1'b1;
                idx = IW'(k);
            end
        end
    end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU among NREQ requesters, one op in flight.
// ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
import alu_pkg::*;
module alu_share_arb #(
    parameter int NREQ = 2,
    parameter int W = ALU_W
) (
    input  logic             clk,
    input  logic             rst,
    alu_share_arb_if.slave   bus,
    output logic [W-1:0]     alu_data1,
    output logic [W-1:0]     alu_data2,
    output logic [2:0]       alu_op,
    input  logic [W-1:0]     alu_result,
    input  logic             alu_zero
);
    localparam int IW = $clog2(NREQ);
    state_t state, nstate;
    logic [IW-1:0] rr, idx, gidx;
    logic [NREQ-1:0] gnt;
    logic take;
    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (.req(bus.req_valid), .ptr(rr), .gnt(gnt), .idx(idx));
    assign take = (state == IDLE) && |bus.req_valid;
    always_comb begin
        nstate = state;
        nstate = (state == IDLE) ? (take ? EXEC : IDLE) :
                 (state == EXEC) ? RESP :
                 (bus.rsp_ready[gidx] ? IDLE : RESP);
        bus.req_ready = (state == IDLE) ? gnt : '0;
        bus.rsp_valid = (state == RESP) ? (NREQ'(1) << gidx) : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rr <= '0;
            gidx <= '0;
            alu_data1 <= '0;
            alu_data2 <= '0;
            alu_op <= ALU_OP_ADD;
            bus.rsp_result <= '0;
            bus.rsp_zero <= 1'b0;
        end else begin
            state <= nstate;
            if (take) begin
                gidx <= idx;
                rr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
                alu_data1 <= bus.req_a[idx*W +: W];
                alu_data2 <= bus.req_b[idx*W +: W];
                alu_op <= bus.req_op[idx*3 +: 3];
            end
            // ALU is combinational on the registered inputs; sample its output at the end of EXEC
            if (state == EXEC) begin
                bus.rsp_result <= alu_result;
                bus.rsp_zero <= alu_zero;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed checks of alu_share_arb with a behavioural ALU attached
module tb_alu_share_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] alu_data1, alu_data2, alu_result;
    logic [2:0] alu_op;
    logic alu_zero;
    int n_tests = 0;
    int n_fail = 0;
    alu_share_arb_if #(.NREQ(2), .W(32)) bus ();
    alu_share_arb #(.NREQ(2), .W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );
    always #5 clk = ~clk;
    always_comb begin
        alu_result = alu_data1 + alu_data2;
        case (alu_op)
            3'b100: alu_result = alu_data1 - alu_data2;
            3'b101: alu_result = alu_data1 | alu_data2;
            3'b110: alu_result = alu_data1 & alu_data2;
            3'b111: alu_result = alu_data1 << alu_data2[4:0];
            default: alu_result = alu_data1 + alu_data2;
        endcase
        alu_zero = (alu_result == 32'd0);
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bus.req_valid[i] = v;
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
        bus.req_op[i*3 +: 3] = op;
    endtask
    // Called at a falling edge with the DUT idle and no other request pending
    task automatic run_op(input string tag, input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [31:0] exp_res, input logic exp_zero);
        logic [1:0] oh;
        oh = 2'b01 << i;
        set_req(i, 1'b1, a, b, op);
        #1 check({tag, ".req_ready"}, 64'(bus.req_ready), 64'(oh));
        @(negedge clk);
        bus.req_valid = '0;
        #1 check({tag, ".busy_ready"}, 64'(bus.req_ready), 64'(0));
        @(negedge clk);
        check({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(oh));
        check({tag, ".result"}, 64'(bus.rsp_result), 64'(exp_res));
        check({tag, ".zero"}, 64'(bus.rsp_zero), 64'(exp_zero));
        bus.rsp_ready = oh;
        @(negedge clk);
        check({tag, ".rsp_drop"}, 64'(bus.rsp_valid), 64'(0));
        bus.rsp_ready = '0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        logic [1:0] g;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_op = '0;
        bus.rsp_ready = '0;
        @(negedge clk);
        check("rst.req_ready", 64'(bus.req_ready), 64'(0));
        check("rst.rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst.result", 64'(bus.rsp_result), 64'(0));
        check("rst.alu_op", 64'(alu_op), 64'(3'b011));
        check("rst.alu_data1", 64'(alu_data1), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("sub", 0, 32'd5, 32'd3, 3'b100, 32'd2, 1'b0);
        run_op("zero", 1, 32'd7, 32'd7, 3'b100, 32'd0, 1'b1);
        run_op("illegal", 1, 32'hFFFF_FFFF, 32'd1, 3'b000, 32'd0, 1'b1);
        // Both requesters valid with responses accepted immediately: one op every 3 cycles
        set_req(0, 1'b1, 32'd1, 32'd1, 3'b011);
        set_req(1, 1'b1, 32'd1, 32'd4, 3'b111);
        bus.rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            g = 2'b01;
`else
            g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
            #1 check("cont.grant", 64'(bus.req_ready), 64'(g));
            @(negedge clk);
            @(negedge clk);
            check("cont.rsp_valid", 64'(bus.rsp_valid), 64'(g));
            check("cont.result", 64'(bus.rsp_result), (g == 2'b01) ? 64'd2 : 64'd16);
            @(negedge clk);
        end
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        @(negedge clk);
        // Backpressure on requester 0 while requester 1 keeps asking; its rsp_ready must be ignored
        set_req(0, 1'b1, 32'd10, 32'd20, 3'b011);
        set_req(1, 1'b1, 32'd3, 32'd3, 3'b101);
        #1 check("bp.grant", 64'(bus.req_ready), 64'(2'b01));
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 2'b10;
        for (int k = 0; k < 5; k++) begin
            #1 check("bp.rsp_valid", 64'(bus.rsp_valid), 64'(2'b01));
            check("bp.result", 64'(bus.rsp_result), 64'd30);
            check("bp.req_ready", 64'(bus.req_ready), 64'(0));
            @(negedge clk);
        end
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        bus.rsp_ready = '0;
        #1 check("bp.rsp_drop", 64'(bus.rsp_valid), 64'(0));
        check("bp.resume", 64'(bus.req_ready), 64'(2'b10));
        bus.req_valid = '0;
        @(negedge clk);
        // Reset while EXEC: the op is lost and nothing is returned
        set_req(0, 1'b1, 32'd1, 32'd2, 3'b011);
        @(negedge clk);
        bus.req_valid = '0;
        check("rexe.alu_data1", 64'(alu_data1), 64'd1);
        rst = 1'b1;
        #1 check("rexe.req_ready", 64'(bus.req_ready), 64'(0));
        check("rexe.rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rexe.result", 64'(bus.rsp_result), 64'(0));
        check("rexe.zero", 64'(bus.rsp_zero), 64'(0));
        check("rexe.alu_data1_clr", 64'(alu_data1), 64'(0));
        check("rexe.alu_data2", 64'(alu_data2), 64'(0));
        check("rexe.alu_op", 64'(alu_op), 64'(3'b011));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rexe.no_rsp", 64'(bus.rsp_valid), 64'(0));
        end
        run_op("post_rst", 1, 32'h0000_00F0, 32'h0000_003C, 3'b110, 32'h0000_0030, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
